bf_r2sdf_stage: RTL

- Parametrised radix-2 DIF single-delay-feedback butterfly stage over LANES parallel complex samples per beat.
- Replaces hard-coded per-stage butterflies with one block whose counters derive from DEPTH.
- Adds input gaps, an explicit burst end with automatic drain, optional scaling, and a twiddle index output for a downstream factor multiplier.

---
 rtl/bf_r2sdf_stage_pkg.sv | 16 +
 rtl/bf_r2sdf_stage_if.sv | 29 ++
 rtl/bf_r2sdf_stage_delay_line.sv | 24 ++
 rtl/bf_r2sdf_stage.sv | 95 +++++++++
 4 files changed

// File: rtl/bf_r2sdf_stage_pkg.sv
// Shared types and helpers for the radix-2 single-delay-feedback butterfly stage.
package bf_pkg;
  localparam int WIDTH_DEF = 10;
  localparam int LANES_DEF = 16;
  localparam int DEPTH_DEF = 8;
  // Derived widths for the default configuration; instances recompute them locally.
  localparam int TW_W = $clog2(DEPTH_DEF);
  localparam int OW   = WIDTH_DEF + 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  // Halve with round-half-up; evaluated wide so s = max positive cannot wrap.
  function automatic logic signed [31:0] rnd_shift(input logic signed [31:0] s);
    return (s + 32'sd1) >>> 1;
  endfunction
endpackage

// File: rtl/bf_r2sdf_stage_if.sv
// Stream bundle: input beats with last flag, output results with twiddle tag.
interface bf_r2sdf_stage_if #(
  parameter int WIDTH = 10,
  parameter int LANES = 16,
  parameter int DEPTH = 8
);
  localparam int TW = $clog2(DEPTH);

  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic [LANES-1:0][WIDTH-1:0]  din_re;
  logic [LANES-1:0][WIDTH-1:0]  din_im;
  logic                         out_valid;
  logic [LANES-1:0][WIDTH:0]    dout_re;
  logic [LANES-1:0][WIDTH:0]    dout_im;
  logic                         out_is_diff;
  logic [TW-1:0]                out_tw_idx;
  logic                         err_last;

  modport master (
    output in_valid, in_last, din_re, din_im,
    input  in_ready, out_valid, dout_re, dout_im, out_is_diff, out_tw_idx, err_last
  );
  modport slave (
    input  in_valid, in_last, din_re, din_im,
    output in_ready, out_valid, dout_re, dout_im, out_is_diff, out_tw_idx, err_last
  );
endinterface

// File: rtl/bf_r2sdf_stage_delay_line.sv
// DEPTH-beat feedback delay: new beat enters at tap 0, head is the oldest beat.
module bf_delay_line
  import bf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LANES = 16,
  parameter int W     = OW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [LANES-1:0][W-1:0] din,
  output logic [LANES-1:0][W-1:0] head
);
  logic [DEPTH-1:0][LANES-1:0][W-1:0] taps;

  // shift one beat toward the head on every advance, frozen otherwise
  always_ff @(posedge clk) begin
    if (rst)     taps <= '0;
    else if (en) taps <= {taps[DEPTH-2:0], din};
  end

  assign head = taps[DEPTH-1];
endmodule

// File: rtl/bf_r2sdf_stage.sv
// Radix-2 DIF SDF butterfly stage: sums leave in the second half of each frame,
// differences recirculate through the delay line and leave DEPTH beats later.
module bf_r2sdf_stage
  import bf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SCALE = 0
) (
  input  logic            clk,
  input  logic            rst,
  bf_r2sdf_stage_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int RES_W = WIDTH + 1;
  localparam logic [IDX_W:0] PH_HALF = (IDX_W+1)'(DEPTH - 1);
  localparam logic [IDX_W:0] PH_END  = (IDX_W+1)'(2*DEPTH - 1);

  state_t          state;
  logic [IDX_W:0]  phase;
  logic            ready, beat, adv, emit, run_sum, at_end;
  logic [LANES-1:0][RES_W-1:0] head_re, head_im, wr_re, wr_im, res_re, res_im;

  assign ready   = (state != DRAIN);
  assign beat    = bus.in_valid & ready;
  // DRAIN needs no input: it steps every cycle to flush the pending differences
  assign adv     = beat | (state == DRAIN);
  assign at_end  = (phase == PH_END);
  // DEPTH is a power of two, so the phase MSB marks the second half-frame
  assign run_sum = (state == RUN) & phase[IDX_W];
  assign emit    = adv & ((state == RUN) | (state == DRAIN));
  assign bus.in_ready = ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [RES_W-1:0] a_re, a_im, b_re, b_im, o_re, o_im;
    assign a_re = $signed(head_re[l]);
    assign a_im = $signed(head_im[l]);
    assign b_re = $signed({bus.din_re[l][WIDTH-1], bus.din_re[l]});
    assign b_im = $signed({bus.din_im[l][WIDTH-1], bus.din_im[l]});
    // second half stores a-b for later; first half stores the raw sample
    assign wr_re[l] = run_sum ? a_re - b_re : (state == DRAIN) ? '0 : b_re;
    assign wr_im[l] = run_sum ? a_im - b_im : (state == DRAIN) ? '0 : b_im;
    assign o_re = run_sum ? a_re + b_re : a_re;
    assign o_im = run_sum ? a_im + b_im : a_im;
    assign res_re[l] = (SCALE != 0) ? RES_W'(rnd_shift(32'(o_re))) : o_re;
    assign res_im[l] = (SCALE != 0) ? RES_W'(rnd_shift(32'(o_im))) : o_im;
  end

  bf_delay_line #(.DEPTH(DEPTH), .LANES(LANES), .W(RES_W)) u_dl_re (
    .clk(clk), .rst(rst), .en(adv), .din(wr_re), .head(head_re)
  );
  bf_delay_line #(.DEPTH(DEPTH), .LANES(LANES), .W(RES_W)) u_dl_im (
    .clk(clk), .rst(rst), .en(adv), .din(wr_im), .head(head_im)
  );

  // frame sequencing: state, phase and sticky misplaced-last flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      bus.err_last <= 1'b0;
    end else begin
      if (beat && bus.in_last && !((state == RUN) && at_end)) bus.err_last <= 1'b1;
      if (state == DRAIN && phase == PH_HALF) phase <= '0;
      else if (adv)                           phase <= at_end ? '0 : phase + 1'b1;
      case (state)
        IDLE:    if (beat) state <= FILL;
        FILL:    if (beat && phase == PH_HALF) state <= RUN;
        RUN:     if (beat && at_end && bus.in_last) state <= DRAIN;
        DRAIN:   if (phase == PH_HALF) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // result register; data holds between valid beats
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.dout_re     <= '0;
      bus.dout_im     <= '0;
      bus.out_is_diff <= 1'b0;
      bus.out_tw_idx  <= '0;
    end else begin
      bus.out_valid <= emit;
      if (emit) begin
        bus.dout_re     <= res_re;
        bus.dout_im     <= res_im;
        bus.out_is_diff <= !run_sum;
        bus.out_tw_idx  <= run_sum ? '0 : phase[IDX_W-1:0];
      end
    end
  end
endmodule
